// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and request record for the iterative RV32M mul/div unit.
package muldiv_unit_pkg;

    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_SIGN = 3'd3,
        MD_FIX  = 3'd4,
        MD_DONE = 3'd5
    } md_state_e;

    // Everything about the accepted op that the back end still needs.
    typedef struct packed {
        logic [4:0] op;
        logic       neg_res;
        logic       neg_rem;
    } md_req_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_signed_div(input logic [4:0] op);
        return op inside {ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, keep or restore.
module muldiv_unit_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] diff;

    // rem_in < divisor always holds, so the true difference fits in XLEN bits.
    assign shifted = {rem_in[XLEN-2:0], dvd_bit};
    assign q_bit   = ({rem_in, dvd_bit} >= {1'b0, divisor});
    assign diff    = shifted - divisor;
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle on magnitudes, sign fixed at the end.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    md_state_e         state;
    md_req_t           req;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;   // product, or {remainder, dividend/quotient}
    logic [XLEN-1:0]   opb;   // multiplicand or divisor magnitude

    logic            sgn_a, sgn_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, fix_res;

    always_comb begin
        sgn_a    = rs1[XLEN-1] & (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        sgn_b    = rs2[XLEN-1] & (op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
        mag_a    = sgn_a ? -rs1 : rs1;
        mag_b    = sgn_b ? -rs2 : rs2;
        div_zero = is_div_op(op) && (rs2 == '0);
        div_ovf  = is_signed_div(op) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        fix_res  = '0;
        if (div_zero)
            fix_res = (op inside {ALU_DIV, ALU_DIVU}) ? '1 : rs1;
        else if (div_ovf)
            fix_res = (op == ALU_DIV) ? rs1 : '0;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] dv_rem;
    logic            dv_q;

    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);

    muldiv_unit_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .dvd_bit (acc[XLEN-1]),
        .divisor (opb),
        .rem_out (dv_rem),
        .q_bit   (dv_q)
    );

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res_sel;

    always_comb begin
        prod = req.neg_res ? -acc : acc;
        quo  = req.neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = req.neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (req.op)
            ALU_MUL:                         res_sel = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: res_sel = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               res_sel = quo;
            default:                         res_sel = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            req    <= '0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (kill && state != MD_IDLE) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                    if (start && !kill) begin
                        req  <= '{op: op, neg_res: sgn_a ^ sgn_b, neg_rem: sgn_a};
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (is_mul_op(op)) begin
                            acc   <= {{XLEN{1'b0}}, mag_b};
                            opb   <= mag_a;
                            state <= MD_MUL;
                        end else if (is_div_op(op) && !div_zero && !div_ovf) begin
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            opb   <= mag_b;
                            state <= MD_DIV;
                        end else begin
                            // Special cases and non-M ops park their answer in acc.
                            acc   <= {{XLEN{1'b0}}, fix_res};
                            opb   <= '0;
                            state <= MD_FIX;
                        end
                    end
                end
                MD_MUL: begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= MD_SIGN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MD_DIV: begin
                    acc <= {dv_rem, acc[XLEN-2:0], dv_q};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= MD_SIGN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MD_SIGN: begin
                    result <= res_sel;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= MD_DONE;
                end
                MD_FIX: begin
                    result <= acc[XLEN-1:0];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= MD_DONE;
                end
                MD_DONE: begin
                    done  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: per-cycle compare against a transaction-level model plus directed literals.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_tests = 0, n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result, straight from the ISA rules.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (is_mul_op(o)) return 34;
        if (!is_div_op(o)) return 2;
        if (b == 0) return 2;
        if (is_signed_div(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Transaction model: one op in flight, done at accept+latency, result sticky.
    int          cyc = 0, done_cyc = 0;
    bit          pend = 0, in_done = 0;
    logic [31:0] pend_res = '0, cur_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            pend = 0; in_done = 0; cur_res = '0;
        end else if (pend && kill) begin
            pend = 0;
        end else if (!pend && !in_done && start && !kill) begin
            pend     = 1;
            done_cyc = cyc + model_lat(op, rs1, rs2);
            pend_res = model(op, rs1, rs2);
        end
        cyc++;
        in_done = 0;
        if (pend && cyc == done_cyc) begin
            in_done = 1; pend = 0; cur_res = pend_res;
        end
        #1;
        chk("cyc_busy", {31'b0, busy}, {31'b0, pend});
        chk("cyc_done", {31'b0, done}, {31'b0, in_done});
        chk("cyc_result", result, cur_res);
    end

    // kind: 0 plain, 1 new start at cycle poke, 2 kill at poke, 3 rst at poke, 4 start in done cycle.
    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int lat,
                          input int poke, input int kind);
        int n = 0, nbusy = 0;
        bit seen = 0;
        start = 1; op = o; rs1 = a; rs2 = b;
        while (n < 60 && !seen) begin
            @(negedge clk); n++;
            if (n == 1) begin start = 0; op = 5'($urandom); rs1 = $urandom; rs2 = $urandom; end
            if (done) seen = 1;
            else if (busy) nbusy++;
            if (n == poke + 1 && kind == 2) begin
                chk({name, "_busy_after_kill"}, {31'b0, busy}, 32'd0);
                chk({name, "_result_after_kill"}, result, lit);
            end
            if (n == poke + 1 && kind == 3) begin
                chk({name, "_busy_after_rst"}, {31'b0, busy}, 32'd0);
                chk({name, "_result_after_rst"}, result, 32'd0);
            end
            if (n == poke) begin
                if (kind == 1) begin start = 1; op = ALU_MUL; rs1 = $urandom; rs2 = $urandom; end
                if (kind == 2) kill = 1;
                if (kind == 3) rst = 1;
            end else if (n == poke + 1) begin
                start = 0; kill = 0; rst = 0;
            end
        end
        start = 0; kill = 0; rst = 0;
        if (kind == 2 || kind == 3) begin
            chk({name, "_no_done"}, {31'b0, seen}, 32'd0);
        end else begin
            chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
            chk({name, "_latency"}, n, lat);
            chk({name, "_busy_cycles"}, nbusy, lat - 1);
            chk({name, "_result"}, result, lit);
        end
        if (kind == 4) begin
            start = 1; op = ALU_MUL; rs1 = 32'd9; rs2 = 32'd9;
            @(negedge clk);
            start = 0;
            chk({name, "_start_in_done_ignored"}, {31'b0, busy}, 32'd0);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 0;

        chk("pin_mul",    model(ALU_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_mulh",   model(ALU_MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("pin_mulhu",  model(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("pin_mulhsu", model(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_div",    model(ALU_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem",    model(ALU_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_divu0",  model(ALU_DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("pin_rem_ovf", model(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
        @(negedge clk);

        run_op("mul",      ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 0);
        run_op("mulh",     ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 0);
        run_op("mulhu",    ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 0);
        run_op("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, 0);
        run_op("div",      ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 0);
        run_op("rem",      ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 0);
        run_op("divu",     ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 0, 0);
        run_op("remu",     ALU_REMU, 32'd100, 32'd7, 32'd2, 34, 0, 0);
        run_op("divu_z",   ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0, 0);
        run_op("remu_z",   ALU_REMU, 32'd5, 32'd0, 32'd5, 2, 0, 0);
        run_op("rem_ovf",  ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 0, 0);
        run_op("div_ovf",  ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, 0);
        run_op("nonm",     5'd3, 32'd1234, 32'd5, 32'h0, 2, 0, 0);
        run_op("remu_z2",  ALU_REMU, 32'd77, 32'd0, 32'd77, 2, 0, 0);
        run_op("div_kill", ALU_DIV, 32'd1000, 32'd3, 32'd77, 0, 10, 2);
        run_op("mul_poke", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5, 1);
        run_op("mulh_rst", ALU_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 0, 20, 3);
        run_op("mul_3x4",  ALU_MUL, 32'd3, 32'd4, 32'd12, 34, 0, 0);
        run_op("done_st",  ALU_DIVU, 32'd50, 32'd5, 32'd10, 34, 0, 4);

        // kill and start together in IDLE: nothing accepted
        start = 1; kill = 1; op = ALU_MUL; rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clk);
        start = 0; kill = 0;
        chk("kill_start_idle", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  o;
            logic [31:0] a, b;
            o = ($urandom_range(0, 9) == 0) ? 5'd2 : ops[$urandom_range(0, 7)];
            a = rnd_opnd();
            b = rnd_opnd();
            run_op("rand", o, a, b, model(o, a, b), model_lat(o, a, b), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
